// File: rtl/aes_dec_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 decryptor.
// S-boxes are computed algebraically (field inverse plus affine map) instead of stored tables.
package aes_dec_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_ADDK,
    ST_ROUND
  } fsm_e;

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = gmul(a, a);
    r = p;
    for (int i = 0; i < 6; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [BLK_W-1:0] state_i,
  input  logic [BLK_W-1:0] rkey_i,
  input  logic             last_i,
  output logic [BLK_W-1:0] nxt_state_c_o
);

  logic [BLK_W-1:0] sr_c;
  logic [BLK_W-1:0] ark_c;
  logic [BLK_W-1:0] mix_c;

  // Byte (r,c) lives at index 4c+r, byte 0 in the top bits.
  always_comb begin
    sr_c = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_c[127-8*(4*c+r) -: 8] = inv_sbox(state_i[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
  end

  assign ark_c = sr_c ^ rkey_i;

  always_comb begin
    mix_c = '0;
    for (int c = 0; c < 4; c++) begin
      mix_c[127-32*c -: 8] = gmul(ark_c[127-32*c -: 8], 8'h0e) ^ gmul(ark_c[119-32*c -: 8], 8'h0b)
                           ^ gmul(ark_c[111-32*c -: 8], 8'h0d) ^ gmul(ark_c[103-32*c -: 8], 8'h09);
      mix_c[119-32*c -: 8] = gmul(ark_c[127-32*c -: 8], 8'h09) ^ gmul(ark_c[119-32*c -: 8], 8'h0e)
                           ^ gmul(ark_c[111-32*c -: 8], 8'h0b) ^ gmul(ark_c[103-32*c -: 8], 8'h0d);
      mix_c[111-32*c -: 8] = gmul(ark_c[127-32*c -: 8], 8'h0d) ^ gmul(ark_c[119-32*c -: 8], 8'h09)
                           ^ gmul(ark_c[111-32*c -: 8], 8'h0e) ^ gmul(ark_c[103-32*c -: 8], 8'h0b);
      mix_c[103-32*c -: 8] = gmul(ark_c[127-32*c -: 8], 8'h0b) ^ gmul(ark_c[119-32*c -: 8], 8'h0d)
                           ^ gmul(ark_c[111-32*c -: 8], 8'h09) ^ gmul(ark_c[103-32*c -: 8], 8'h0e);
    end
  end

  assign nxt_state_c_o = last_i ? ark_c : mix_c;

endmodule

// File: rtl/aes_dec_round.sv
// Iterative AES-128 decryptor: forward key expansion to k10, then ten inverse rounds
// regenerating round keys backwards. Optional key cache: define AES_DEC_KEYCACHE_EN.
module aes_dec_round
  import aes_dec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BLK_W-1:0] CT,
  input  logic [BLK_W-1:0] KEY,
  output logic [BLK_W-1:0] DEC,
  output logic             busy,
  output logic             done
);

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [CNT_W-1:0] rnd_q, rnd_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic [BLK_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] dec_q, dec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_c;
`ifdef AES_DEC_KEYCACHE_EN
  logic [BLK_W-1:0] ckey_q, ckey_d;
  logic [BLK_W-1:0] ck10_q, ck10_d;
  logic             cvld_q, cvld_d;
`endif

  logic [31:0]      fw0_c, fw1_c, fw2_c, fw3_c;
  logic [31:0]      iw0_c, iw1_c, iw2_c, iw3_c;
  logic [BLK_W-1:0] key_fwd_c, key_inv_c, round_c;

  // Forward key step k(rcnt-1) -> k(rcnt).
  assign fw0_c     = key_q[127:96] ^ sub_word(rot_word(key_q[31:0])) ^ {rcon(rcnt_q), 24'h0};
  assign fw1_c     = key_q[95:64] ^ fw0_c;
  assign fw2_c     = key_q[63:32] ^ fw1_c;
  assign fw3_c     = key_q[31:0] ^ fw2_c;
  assign key_fwd_c = {fw0_c, fw1_c, fw2_c, fw3_c};

  // Inverse key step k(rnd+1) -> k(rnd).
  assign iw3_c     = key_q[31:0] ^ key_q[63:32];
  assign iw2_c     = key_q[63:32] ^ key_q[95:64];
  assign iw1_c     = key_q[95:64] ^ key_q[127:96];
  assign iw0_c     = key_q[127:96] ^ sub_word(rot_word(iw3_c)) ^ {rcon(CNT_W'(rnd_q + 4'd1)), 24'h0};
  assign key_inv_c = {iw0_c, iw1_c, iw2_c, iw3_c};

  aes_inv_round u_inv_round (
    .state_i       (blk_q),
    .rkey_i        (key_inv_c),
    .last_i        (rnd_q == '0),
    .nxt_state_c_o (round_c)
  );

  always_comb begin
    fsm_d    = fsm_q;
    rcnt_d   = rcnt_q;
    rnd_d    = rnd_q;
    ct_d     = ct_q;
    key_d    = key_q;
    blk_d    = blk_q;
    dec_d    = dec_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    accept_c = 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
    ckey_d   = ckey_q;
    ck10_d   = ck10_q;
    cvld_d   = cvld_q;
`endif
    case (fsm_q)
      ST_IDLE: accept_c = start;
      ST_EXPAND: begin
        key_d  = key_fwd_c;
        rcnt_d = CNT_W'(rcnt_q + 4'd1);
        if (rcnt_q == CNT_W'(NR)) begin
          fsm_d = ST_ADDK;
`ifdef AES_DEC_KEYCACHE_EN
          ck10_d = key_fwd_c;
          cvld_d = 1'b1;
`endif
        end
      end
      ST_ADDK: begin
        blk_d = ct_q ^ key_q;
        rnd_d = CNT_W'(NR - 1);
        fsm_d = ST_ROUND;
      end
      ST_ROUND: begin
        key_d = key_inv_c;
        blk_d = round_c;
        if (rnd_q == '0) begin
          dec_d    = round_c;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          fsm_d    = ST_IDLE;
          // Completing edge also accepts, giving one block per 21 cycles back-to-back.
          accept_c = start;
        end else begin
          rnd_d = CNT_W'(rnd_q - 4'd1);
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    if (accept_c) begin
      ct_d   = CT;
      key_d  = KEY;
      busy_d = 1'b1;
      rcnt_d = CNT_W'(1);
      fsm_d  = ST_EXPAND;
`ifdef AES_DEC_KEYCACHE_EN
      if (cvld_q && (KEY == ckey_q)) begin
        key_d = ck10_q;
        fsm_d = ST_ADDK;
      end else begin
        ckey_d = KEY;
        cvld_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q  <= ST_IDLE;
      rcnt_q <= '0;
      rnd_q  <= '0;
      ct_q   <= '0;
      key_q  <= '0;
      blk_q  <= '0;
      dec_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
      ckey_q <= '0;
      ck10_q <= '0;
      cvld_q <= 1'b0;
`endif
    end else begin
      fsm_q  <= fsm_d;
      rcnt_q <= rcnt_d;
      rnd_q  <= rnd_d;
      ct_q   <= ct_d;
      key_q  <= key_d;
      blk_q  <= blk_d;
      dec_q  <= dec_d;
      busy_q <= busy_d;
      done_q <= done_d;
`ifdef AES_DEC_KEYCACHE_EN
      ckey_q <= ckey_d;
      ck10_q <= ck10_d;
      cvld_q <= cvld_d;
`endif
    end
  end

  assign DEC  = dec_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/aes_dec_round.md
AES_DEC_ROUND -- requirements
Module: aes_dec_round

Interface
REQ-001 SHALL have port clk, input, 1: rising-edge system clock.
REQ-002 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1: request pulse, sampled on clk rise.
REQ-004 SHALL have port CT, input, 128: ciphertext block, byte 0 in [127:120].
REQ-005 SHALL have port KEY, input, 128: AES-128 cipher key (round key 0), same byte order.
REQ-006 SHALL have port DEC, output, 128: registered plaintext result.
REQ-007 SHALL have port busy, output, 1: high from the accepting edge until result is written.
REQ-008 SHALL have port done, output, 1: one-cycle pulse when DEC updates.

Function
REQ-009 SHALL implement FSM IDLE -> EXPAND -> ADDK -> ROUND -> IDLE.
REQ-010 IDLE: start=1 at edge T0 SHALL latch CT and KEY, set busy=1, enter EXPAND with rcnt=1.
REQ-011 EXPAND: each edge SHALL apply the forward key step with Rcon(rcnt) and increment rcnt; after rcnt=10 (edge T10), round key k10 SHALL be held and the FSM SHALL enter ADDK.
REQ-012 ADDK (edge T11): state SHALL be set to CT xor k10, rnd SHALL be set to 9, and the FSM SHALL enter ROUND.
REQ-013 ROUND: each edge SHALL regenerate k(rnd) from k(rnd+1) by inverse key step: w3'=w3^w2, w2'=w2^w1, w1'=w1^w0, w0'=w0^SubWord(RotWord(w3'))^Rcon(rnd+1).
REQ-014 For rnd 9..1, state SHALL become InvMixColumns(InvSubBytes(InvShiftRows(state)) xor k(rnd)); rnd SHALL decrement.
REQ-015 For rnd=0 (edge T21), the result InvSubBytes(InvShiftRows(state)) xor k0 SHALL be written to DEC; done=1 and busy=0 SHALL follow in the next cycle; the FSM SHALL return to IDLE.
REQ-016 Without the cache, start-to-done latency SHALL be 21 cycles.
REQ-017 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-018 start in the cycle done=1 SHALL be accepted; back-to-back throughput SHALL be one block per 21 cycles.
REQ-019 DEC SHALL hold its last value until the next completion; CT/KEY changes after the accepting edge SHALL have no effect.
REQ-020 All byte arithmetic SHALL be GF(2^8) with polynomial 0x11B; InvMixColumns coefficients SHALL be 0e,0b,0d,09.

Reset
REQ-021 reset=0 SHALL force IDLE, DEC=0, busy=0, done=0, rcnt=0, rnd=0, and invalidate the key cache.
REQ-022 Reset mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL begin a fresh operation.

Configuration
REQ-023 With AES_DEC_KEYCACHE_EN defined, the block SHALL store KEY and k10 with a valid flag after each EXPAND.
REQ-024 With it defined, a start whose KEY equals the valid cached key SHALL skip EXPAND (IDLE -> ADDK) and give 11-cycle latency; a different KEY SHALL expand and refresh the cache.
REQ-025 Without the macro, no cache registers SHALL exist, and every operation SHALL take 21 cycles.

Structure
REQ-026 Package aes_dec_pkg SHALL hold: FSM state typedef, NR=10, the Rcon table, sbox/inv_sbox and xtime/gmul functions.
REQ-027 Sub-module aes_inv_round SHALL be combinational (state, round key, last flag -> next state); the key step and FSM SHALL reside in aes_dec_round.

Verification
REQ-028 Bench: KEY=000102030405060708090a0b0c0d0e0f, CT=69c4e0d86a7b0430d8cdb78070b4c55a, start pulse -> done 21 cycles later, DEC=00112233445566778899aabbccddeeff.
REQ-029 Bench: KEY=2b7e151628aed2a6abf7158809cf4f3c, CT=3925841d02dc09fbdc118597196a0b32 -> DEC=3243f6a8885a308d313198a2e0370734.
REQ-030 Bench: start held high for 30 cycles -> exactly one done pulse at cycle 21, then a second accepted operation with done at cycle 42.
REQ-031 Bench: reset=0 at cycle 8 of an operation -> DEC=0, busy=0, no done; a new start then yields the correct result at +21.
REQ-032 Bench: with AES_DEC_KEYCACHE_EN, repeat REQ-028 twice with the same KEY -> second done after 11 cycles; a changed KEY -> 21 cycles.
